spi_rx_frame_slave: RTL and testbench
=====================================

// Module: spi_rx_frame_slave
// PURPOSE
//  SPI-slave receive deframer that sits directly upstream of the slave CRC checker.
//  It oversamples spi_sclk/spi_cs_n/spi_mosi in the clk domain and shifts in one 32-bit packet per chip-select window, MSB first.
//  On a valid frame it presents rx_data (24b) and rx_crc (8b) to the CRC checker, using a valid/ready output buffer.
//  Malformed frames (wrong bit count) and overruns are reported as 1-cycle error pulses.
// PARAMETERS
//  LEN_PACKET   32    bits per frame; must equal LEN_DATA+LEN_CRC
//  LEN_DATA     24    payload bits; frame bits [31:8]
//  LEN_CRC      8     CRC bits; frame bits [7:0]
//  SYNC_STAGES  2     flop stages in each input synchroniser; minimum 2
//  TIMEOUT_CYC  1024  idle-sclk abort limit in clk cycles; used only with SPI_RX_TIMEOUT_EN
// PORTS
//  clk        in   1   system clock; must run at >= 4x spi_sclk
//  rst_n      in   1   asynchronous active-low reset
//  spi_sclk   in   1   SPI clock, asynchronous to clk; mode 0, mosi sampled on rising edge
//  spi_cs_n   in   1   SPI chip select, active low, asynchronous
//  spi_mosi   in   1   SPI data in, asynchronous; first bit sent = data[23]
//  rx_data    out  24  received payload; held stable while rx_valid=1
//  rx_crc     out  8   received CRC byte; held stable while rx_valid=1
//  rx_valid   out  1   frame available; stays high until accepted
//  rx_ready   in   1   consumer accept; the transfer completes on a clk edge where rx_valid & rx_ready
//  err_len    out  1   1-cycle pulse: a frame ended with bit count != LEN_PACKET
//  err_ovr    out  1   1-cycle pulse: a good frame was dropped because the buffer was still full
//  busy       out  1   high while state != IDLE
// BEHAVIOUR
//  Reset values: rx_data=0, rx_crc=0, rx_valid=0, err_len=0, err_ovr=0, busy=0.
//    Shift register, bit counter and sync flops reset to 0; cs sync flops reset to 1.
//  Synchronisers: each input passes through a SYNC_STAGES flop chain.
//    Edges are detected by comparing the last sync stage with a registered copy.
//  FSM states: IDLE, SHIFT, ABORT.
//  IDLE -> SHIFT: on a synchronised cs_n falling edge. Clears the shift register and bit_cnt.
//  SHIFT, on each sclk rising edge:
//    - shift_reg <= {shift_reg[30:0], mosi_sync};
//    - bit_cnt increments and saturates at LEN_PACKET+1 (6-bit counter).
//  SHIFT -> IDLE: on a cs_n rising edge.
//    - If bit_cnt == 32, commit the frame. Otherwise pulse err_len and discard.
//  Commit, in the cycle after the cs_n rising edge is detected:
//    - If rx_valid==0, or (rx_valid & rx_ready) in that same cycle: load rx_data=shift_reg[31:8], rx_crc=shift_reg[7:0], and set rx_valid=1.
//    - Otherwise keep the old frame and pulse err_ovr.
//  Latency: rx_valid rises SYNC_STAGES+2 clk cycles after the cs_n rising edge at the pin.
//  rx_valid clears on the clk edge where rx_valid & rx_ready, unless a commit coincides (new frame loaded, rx_valid stays 1).
//  An sclk edge and a cs_n rising edge detected in the same cycle: the sclk bit is shifted first, then bit_cnt is evaluated.
//  cs_n falling edge while in SHIFT: impossible without a rise; a glitch is treated as rise-then-fall.
//  The frame is then judged by the rise rule and reception restarts.
//  A long frame (more than 32 bits) gives err_len; the saturating counter never wraps back to 32.
//  rst_n asserted mid-frame: everything returns to reset values immediately and the partial frame is lost.
//    After reset, a frame already in progress (cs_n low) is ignored until cs_n goes high and then low again.
//  Output buffer contents are never modified by error frames.
// CONFIGURATION
//  SPI_RX_TIMEOUT_EN defined:
//    - A 16-bit idle counter runs in SHIFT. It resets on every sclk rising edge.
//    - When the counter reaches TIMEOUT_CYC: pulse err_len and go to ABORT.
//    - ABORT ignores sclk and returns to IDLE on the cs_n rising edge, with no further err_len.
//  SPI_RX_TIMEOUT_EN undefined:
//    - No counter, no ABORT state. SHIFT waits indefinitely for cs_n; TIMEOUT_CYC is unused.
// TESTING
//  1 Send 32b 0xA5C30F97 with rx_ready=1 -> rx_data=0xA5C30F, rx_crc=0x97.
//    rx_valid is a 1-cycle pulse SYNC_STAGES+2 clks after cs_n rises; no errors.
//  2 Send 31 bits, then 33 bits -> err_len pulses twice; rx_valid stays 0; rx_data unchanged.
//  3 rx_ready=0; send 0x11223344 then 0x55667788 -> rx_valid=1 holding 0x112233/0x44, and err_ovr pulses once.
//    Then raise rx_ready -> accepts the first frame; rx_valid drops next cycle.
//  4 rx_ready=1 asserted in the exact commit cycle of a second frame -> first accepted, second loaded, rx_valid stays 1, no err_ovr.
//  5 Assert rst_n=0 after 16 bits; release with cs_n still low; finish the frame.
//    -> No rx_valid and no err_len. The next full frame 0xFFFFFF00 gives rx_data=0xFFFFFF, rx_crc=0x00.
//  6 (SPI_RX_TIMEOUT_EN, TIMEOUT_CYC=64) Stop sclk for 64 clks mid-frame.
//    -> err_len pulse, busy stays 1 until cs_n rises, then the next frame is received normally.

Source files
------------

// File: rtl/spi_rx_frame_slave_if.sv
// SPI pins plus the valid/ready frame output of the SPI receive deframer.
interface spi_rx_frame_slave_if #(
  parameter int unsigned LEN_DATA = 24,
  parameter int unsigned LEN_CRC  = 8
);
  logic                spi_sclk;
  logic                spi_cs_n;
  logic                spi_mosi;
  logic [LEN_DATA-1:0] rx_data;
  logic [LEN_CRC-1:0]  rx_crc;
  logic                rx_valid;
  logic                rx_ready;
  logic                err_len;
  logic                err_ovr;
  logic                busy;

  modport slave (
    input  spi_sclk, spi_cs_n, spi_mosi, rx_ready,
    output rx_data, rx_crc, rx_valid, err_len, err_ovr, busy
  );

  modport master (
    output spi_sclk, spi_cs_n, spi_mosi, rx_ready,
    input  rx_data, rx_crc, rx_valid, err_len, err_ovr, busy
  );
endinterface

// File: rtl/spi_rx_frame_slave.sv
// SPI-slave receive deframer: oversampled SPI mode 0, one MSB-first packet per chip-select window.
// Optional idle-sclk abort is compiled in with `define SPI_RX_TIMEOUT_EN.
module spi_rx_frame_slave #(
  parameter int unsigned LEN_PACKET  = 32,
  parameter int unsigned LEN_DATA    = 24,
  parameter int unsigned LEN_CRC     = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input logic                 clk,
  input logic                 rst_n,
  spi_rx_frame_slave_if.slave bus
);

  localparam int unsigned CNT_W = 6;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(LEN_PACKET);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(LEN_PACKET + 1);
`ifdef SPI_RX_TIMEOUT_EN
  localparam int unsigned IDLE_W = 16;
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYC - 1);
`endif

  // Elaboration-time parameter sanity
  if (LEN_PACKET != LEN_DATA + LEN_CRC) begin : g_bad_len
    $error("LEN_PACKET must equal LEN_DATA + LEN_CRC");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be at least 2");
  end
  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYC must fit a 16-bit idle counter");
  end

`ifdef SPI_RX_TIMEOUT_EN
  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_ABORT} state_t;
`else
  typedef enum logic {ST_IDLE, ST_SHIFT} state_t;
`endif

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, cs_sync;
  logic                   sclk_d, cs_d;
  logic [SYNC_STAGES:0]   flush_sr;
  logic                   cs_armed;
  logic                   sclk_rise, cs_rise, cs_fall, mosi_s, cs_s;

  logic [LEN_PACKET-1:0]  shift_reg, shift_nxt, sh_cur, frame_q, frame_nxt;
  logic [CNT_W-1:0]       bit_cnt, cnt_nxt, cnt_cur;
  logic                   commit_pend, commit_nxt, err_len_nxt;
`ifdef SPI_RX_TIMEOUT_EN
  logic [IDLE_W-1:0]      idle_cnt, idle_nxt;
`endif

  logic [LEN_DATA-1:0]    rx_data_q;
  logic [LEN_CRC-1:0]     rx_crc_q;
  logic                   rx_valid_q, err_len_q, err_ovr_q, busy_q;

  // Input synchronisers; cs_armed blocks the reset-value "1" of the cs chain from
  // faking a falling edge when reset releases in the middle of a frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      mosi_sync <= '0;
      cs_sync   <= '1;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b1;
      flush_sr  <= '0;
      cs_armed  <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.spi_sclk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.spi_mosi};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], bus.spi_cs_n};
      sclk_d    <= sclk_sync[SYNC_STAGES-1];
      cs_d      <= cs_sync[SYNC_STAGES-1];
      flush_sr  <= {flush_sr[SYNC_STAGES-1:0], 1'b1};
      if (flush_sr[SYNC_STAGES] && cs_sync[SYNC_STAGES-1]) cs_armed <= 1'b1;
    end
  end

  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_sync[SYNC_STAGES-1] & ~sclk_d;
  assign cs_rise   = cs_armed & cs_s & ~cs_d;
  assign cs_fall   = cs_armed & ~cs_s & cs_d;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next state and frame judgement; a same-cycle sclk bit is shifted before judging
  always_comb begin
    state_nxt   = state;
    shift_nxt   = shift_reg;
    cnt_nxt     = bit_cnt;
    frame_nxt   = frame_q;
    commit_nxt  = 1'b0;
    err_len_nxt = 1'b0;
    sh_cur      = shift_reg;
    cnt_cur     = bit_cnt;
`ifdef SPI_RX_TIMEOUT_EN
    idle_nxt    = '0;
`endif
    if (sclk_rise) begin
      sh_cur  = {shift_reg[LEN_PACKET-2:0], mosi_s};
      cnt_cur = (bit_cnt == CNT_SAT) ? bit_cnt : bit_cnt + CNT_W'(1);
    end
    case (state)
      ST_IDLE: begin
        if (cs_fall) begin
          state_nxt = ST_SHIFT;
          shift_nxt = '0;
          cnt_nxt   = '0;
        end
      end
      ST_SHIFT: begin
        shift_nxt = sh_cur;
        cnt_nxt   = cnt_cur;
        if (cs_rise || cs_fall) begin
          if (cnt_cur == CNT_FULL) begin
            commit_nxt = 1'b1;
            frame_nxt  = sh_cur;
          end else begin
            err_len_nxt = 1'b1;
          end
          state_nxt = ST_IDLE;
          // A fall seen here is a cs glitch: judge as a rise, then restart
          if (cs_fall) begin
            state_nxt = ST_SHIFT;
            shift_nxt = '0;
            cnt_nxt   = '0;
          end
        end
`ifdef SPI_RX_TIMEOUT_EN
        else if (!sclk_rise) begin
          if (idle_cnt == IDLE_LAST) begin
            err_len_nxt = 1'b1;
            state_nxt   = ST_ABORT;
          end else begin
            idle_nxt = idle_cnt + IDLE_W'(1);
          end
        end
      end
      ST_ABORT: begin
        if (cs_rise) state_nxt = ST_IDLE;
`endif
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Receive datapath and status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg   <= '0;
      bit_cnt     <= '0;
      frame_q     <= '0;
      commit_pend <= 1'b0;
      err_len_q   <= 1'b0;
      busy_q      <= 1'b0;
`ifdef SPI_RX_TIMEOUT_EN
      idle_cnt    <= '0;
`endif
    end else begin
      shift_reg   <= shift_nxt;
      bit_cnt     <= cnt_nxt;
      frame_q     <= frame_nxt;
      commit_pend <= commit_nxt;
      err_len_q   <= err_len_nxt;
      busy_q      <= (state_nxt != ST_IDLE);
`ifdef SPI_RX_TIMEOUT_EN
      idle_cnt    <= idle_nxt;
`endif
    end
  end

  // Output buffer: a commit may reuse the slot freed by a same-cycle accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data_q  <= '0;
      rx_crc_q   <= '0;
      rx_valid_q <= 1'b0;
      err_ovr_q  <= 1'b0;
    end else begin
      err_ovr_q <= 1'b0;
      if (commit_pend) begin
        if (!rx_valid_q || bus.rx_ready) begin
          rx_data_q  <= frame_q[LEN_PACKET-1:LEN_CRC];
          rx_crc_q   <= frame_q[LEN_CRC-1:0];
          rx_valid_q <= 1'b1;
        end else begin
          err_ovr_q <= 1'b1;
        end
      end else if (rx_valid_q && bus.rx_ready) begin
        rx_valid_q <= 1'b0;
      end
    end
  end

  assign bus.rx_data  = rx_data_q;
  assign bus.rx_crc   = rx_crc_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.err_len  = err_len_q;
  assign bus.err_ovr  = err_ovr_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_spi_rx_frame_slave.sv
// Bench for spi_rx_frame_slave: a pin-level timeline model predicts every output cycle by cycle.
module tb_spi_rx_frame_slave;
  localparam int unsigned S  = 2;
  localparam int unsigned TO = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_rx_frame_slave_if bus ();
  spi_rx_frame_slave #(.SYNC_STAGES(S), .TIMEOUT_CYC(TO)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_cmp = 0, n_fail = 0, cyc = 0;
  int n_err_len = 0, n_ovr = 0, n_vrise = 0;
  logic prev_valid = 1'b0;

  // Model state: output buffer plus events scheduled from pin activity
  logic        m_valid = 1'b0, m_err_len = 1'b0, m_ovr = 1'b0, m_busy = 1'b0;
  logic [23:0] m_data = '0;
  logic [7:0]  m_crc = '0;
  bit          ev_err[int];
  bit          ev_busy[int];
  logic [31:0] ev_commit[int];
  bit          armed = 1'b1, open = 1'b0;
  int          nbits = 0, last_evt = 0, open_cyc = 0, abort_at = 0;
  logic [31:0] fbits = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid = 1'b0; m_err_len = 1'b0; m_ovr = 1'b0; m_busy = 1'b0;
      m_data = '0; m_crc = '0;
    end else begin
      logic [31:0] f;
      cyc++;
      m_err_len = (ev_err.exists(cyc) != 0);
      m_ovr = 1'b0;
      if (ev_busy.exists(cyc) != 0) m_busy = ev_busy[cyc];
      if (ev_commit.exists(cyc) != 0) begin
        f = ev_commit[cyc];
        if (!m_valid || bus.rx_ready) begin
          m_valid = 1'b1; m_data = f[31:8]; m_crc = f[7:0];
        end else begin
          m_ovr = 1'b1;
        end
      end else if (m_valid && bus.rx_ready) begin
        m_valid = 1'b0;
      end
`ifdef SPI_RX_TIMEOUT_EN
      if (open && abort_at <= open_cyc && cyc == last_evt + int'(S) + 1 + int'(TO)) begin
        m_err_len = 1'b1;
        abort_at = cyc;
      end
`endif
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (rst_n) begin
      check("rx_valid", 32'(bus.rx_valid), 32'(m_valid));
      check("rx_data",  32'(bus.rx_data),  32'(m_data));
      check("rx_crc",   32'(bus.rx_crc),   32'(m_crc));
      check("err_len",  32'(bus.err_len),  32'(m_err_len));
      check("err_ovr",  32'(bus.err_ovr),  32'(m_ovr));
      check("busy",     32'(bus.busy),     32'(m_busy));
      if (bus.err_len) n_err_len++;
      if (bus.err_ovr) n_ovr++;
      if (bus.rx_valid && !prev_valid) n_vrise++;
    end
    prev_valid = bus.rx_valid;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_bit(input logic b);
    @(negedge clk); bus.spi_mosi = b;
    repeat (3) @(negedge clk);
    bus.spi_sclk = 1'b1;
    if (open) begin
      fbits = {fbits[30:0], b}; nbits++; last_evt = cyc;
    end
    repeat (4) @(negedge clk);
    bus.spi_sclk = 1'b0;
  endtask

  task automatic frame_start();
    @(negedge clk); bus.spi_cs_n = 1'b0;
    if (armed) begin
      open = 1'b1; open_cyc = cyc; nbits = 0; fbits = '0; last_evt = cyc;
      ev_busy[cyc + int'(S) + 1] = 1'b1;
    end
    idle(2);
  endtask

  task automatic frame_end(output int rc);
    idle(2);
    bus.spi_cs_n = 1'b1;
    rc = cyc;
    if (open) begin
      ev_busy[cyc + int'(S) + 1] = 1'b0;
      if (abort_at <= open_cyc) begin
        if (nbits == 32) ev_commit[cyc + int'(S) + 2] = fbits;
        else             ev_err[cyc + int'(S) + 1] = 1'b1;
      end
    end
    open = 1'b0; armed = 1'b1;
  endtask

  task automatic send_frame(input logic [63:0] v, input int nb, output int rc);
    frame_start();
    for (int i = nb - 1; i >= 0; i--) spi_bit(v[i]);
    frame_end(rc);
  endtask

  task automatic wait_valid(input int max, output bit got);
    got = 1'b0;
    for (int i = 0; i < max && !got; i++) begin
      @(negedge clk);
      if (bus.rx_valid) got = 1'b1;
    end
  endtask

  initial begin
    int rc, e0, o0, v0;
    bit got;
    bus.spi_cs_n = 1'b1; bus.spi_sclk = 1'b0; bus.spi_mosi = 1'b0; bus.rx_ready = 1'b0;
    rst_n = 1'b0;
    idle(3);
    check("reset_rx_valid", 32'(bus.rx_valid), 32'h0);
    check("reset_rx_data",  32'(bus.rx_data),  32'h0);
    check("reset_rx_crc",   32'(bus.rx_crc),   32'h0);
    check("reset_err_len",  32'(bus.err_len),  32'h0);
    check("reset_err_ovr",  32'(bus.err_ovr),  32'h0);
    check("reset_busy",     32'(bus.busy),     32'h0);
    rst_n = 1'b1;
    idle(8);

    // 1: good frame, consumer always ready
    bus.rx_ready = 1'b1; e0 = n_err_len; o0 = n_ovr;
    send_frame(64'hA5C30F97, 32, rc);
    wait_valid(40, got);
    check("t1_valid_seen", 32'(got), 32'h1);
    check("t1_latency",    32'(cyc - rc), 32'(S + 2));
    check("t1_rx_data",    32'(bus.rx_data), 32'h00A5C30F);
    check("t1_rx_crc",     32'(bus.rx_crc),  32'h00000097);
    check("t1_model_data", 32'(m_data), 32'h00A5C30F);
    @(negedge clk);
    check("t1_valid_pulse", 32'(bus.rx_valid), 32'h0);
    idle(8);
    check("t1_no_err_len", 32'(n_err_len - e0), 32'h0);
    check("t1_no_err_ovr", 32'(n_ovr - o0), 32'h0);

    // 2: short then long frame
    e0 = n_err_len; v0 = n_vrise;
    send_frame(64'h12345678, 31, rc);
    idle(6);
    send_frame(64'h1ABCDEF01, 33, rc);
    idle(8);
    check("t2_err_len_count", 32'(n_err_len - e0), 32'h2);
    check("t2_no_valid",      32'(n_vrise - v0), 32'h0);
    check("t2_data_kept",     32'(bus.rx_data), 32'h00A5C30F);

    // 3: overrun while consumer stalls
    bus.rx_ready = 1'b0; o0 = n_ovr;
    send_frame(64'h11223344, 32, rc);
    idle(6);
    send_frame(64'h55667788, 32, rc);
    idle(8);
    check("t3_valid_held", 32'(bus.rx_valid), 32'h1);
    check("t3_rx_data",    32'(bus.rx_data), 32'h00112233);
    check("t3_rx_crc",     32'(bus.rx_crc),  32'h00000044);
    check("t3_ovr_count",  32'(n_ovr - o0), 32'h1);
    bus.rx_ready = 1'b1;
    @(negedge clk);
    bus.rx_ready = 1'b0;
    check("t3_valid_drop", 32'(bus.rx_valid), 32'h0);

    // 4: accept coincides with the commit of the next frame
    send_frame(64'h0A0B0C0D, 32, rc);
    idle(6);
    o0 = n_ovr;
    send_frame(64'hDEADBEEF, 32, rc);
    while (cyc < rc + int'(S) + 1) @(negedge clk);
    bus.rx_ready = 1'b1;
    @(negedge clk);
    bus.rx_ready = 1'b0;
    check("t4_valid_stays", 32'(bus.rx_valid), 32'h1);
    check("t4_rx_data",     32'(bus.rx_data), 32'h00DEADBE);
    check("t4_rx_crc",      32'(bus.rx_crc),  32'h000000EF);
    idle(4);
    check("t4_no_ovr", 32'(n_ovr - o0), 32'h0);
    bus.rx_ready = 1'b1;
    idle(2);

    // 5: reset mid-frame, tail of that frame must be ignored
    frame_start();
    for (int i = 15; i >= 0; i--) spi_bit(1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    open = 1'b0; armed = 1'b0;
    ev_err.delete(); ev_busy.delete(); ev_commit.delete();
    idle(3);
    rst_n = 1'b1;
    e0 = n_err_len; v0 = n_vrise;
    for (int i = 15; i >= 0; i--) spi_bit(1'b0);
    frame_end(rc);
    idle(8);
    check("t5_no_err_len", 32'(n_err_len - e0), 32'h0);
    check("t5_no_valid",   32'(n_vrise - v0), 32'h0);
    send_frame(64'hFFFFFF00, 32, rc);
    wait_valid(40, got);
    check("t5_valid_seen", 32'(got), 32'h1);
    check("t5_rx_data",    32'(bus.rx_data), 32'h00FFFFFF);
    check("t5_rx_crc",     32'(bus.rx_crc),  32'h00000000);
    idle(4);

`ifdef SPI_RX_TIMEOUT_EN
    // 6: sclk stalls mid-frame
    e0 = n_err_len; v0 = n_vrise;
    frame_start();
    for (int i = 9; i >= 0; i--) spi_bit(i[0]);
    idle(int'(TO) + 20);
    for (int i = 2; i >= 0; i--) spi_bit(1'b1);
    check("t6_busy_abort", 32'(bus.busy), 32'h1);
    frame_end(rc);
    idle(8);
    check("t6_err_len_once", 32'(n_err_len - e0), 32'h1);
    check("t6_no_valid",     32'(n_vrise - v0), 32'h0);
    send_frame(64'h0BADF00D, 32, rc);
    wait_valid(40, got);
    check("t6_valid_seen", 32'(got), 32'h1);
    check("t6_rx_data",    32'(bus.rx_data), 32'h000BADF0);
    check("t6_rx_crc",     32'(bus.rx_crc),  32'h0000000D);
`endif

    idle(10);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
